// File: rtl/cpu_pkg.sv
// Shared CPU constants: default datapath sizes and ALU function codes.
// Consumed by operand_fetch and its register file.
package cpu_pkg;

  localparam int CPU_DATA_W = 24;
  localparam int CPU_REG_AW = 4;

  // FN_LOGIC covers 00xx and FN_SHIFT covers 111x; the low bits select
  // the variant inside the ALU.
  localparam logic [3:0] FN_LOGIC = 4'b0000;
  localparam logic [3:0] FN_ADD   = 4'b0100;
  localparam logic [3:0] FN_SUB   = 4'b0101;
  localparam logic [3:0] FN_MUL   = 4'b0110;
  localparam logic [3:0] FN_SLT   = 4'b0111;
  localparam logic [3:0] FN_SHIFT = 4'b1110;

  function automatic logic is_shift(input logic [3:0] f);
    return f[3:1] == 3'b111;
  endfunction

endpackage

// File: rtl/operand_fetch_regfile.sv
// Register file: two async read ports, one sync write port.
// Entry 0 is never written, so it reads 0 from reset onward.
module regfile
  import cpu_pkg::*;
#(
  parameter int DATA_W = CPU_DATA_W,
  parameter int REG_AW = CPU_REG_AW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] ra1,
  input  logic [REG_AW-1:0] ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  input  logic              we,
  input  logic [REG_AW-1:0] wa,
  input  logic [DATA_W-1:0] wd
);

  localparam int NREG = 1 << REG_AW;

  logic [DATA_W-1:0] mem [NREG];

  // Storage update: cleared by reset, r0 writes dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) mem[i] <= '0;
    end else if (we && (wa != '0)) begin
      mem[wa] <= wd;
    end
  end

  assign rd1 = mem[ra1];
  assign rd2 = mem[ra2];

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch stage: reads sources, registers ALU operands and tags.
// OPERAND_FETCH_BYPASS_EN enables writeback forwarding and held refresh.
module operand_fetch
  import cpu_pkg::*;
#(
  parameter int DATA_W = CPU_DATA_W,
  parameter int REG_AW = CPU_REG_AW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [REG_AW-1:0] rs1,
  input  logic [REG_AW-1:0] rs2,
  input  logic [REG_AW-1:0] rd,
  input  logic [3:0]        funct,
  input  logic [DATA_W-1:0] imm,
  input  logic              use_imm,
  input  logic              wb_en,
  input  logic [REG_AW-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] a,
  output logic [DATA_W-1:0] b,
  output logic [3:0]        out_funct,
  output logic [REG_AW-1:0] out_rd
);

  logic [DATA_W-1:0] rf1;
  logic [DATA_W-1:0] rf2;
  logic [DATA_W-1:0] opa;
  logic [DATA_W-1:0] opb;
  logic              take;
  logic              wb_live;

  regfile #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_rf (
    .clk (clk),
    .rst (rst),
    .ra1 (rs1),
    .ra2 (rs2),
    .rd1 (rf1),
    .rd2 (rf2),
    .we  (wb_en),
    .wa  (wb_addr),
    .wd  (wb_data)
  );

  assign in_ready = !out_valid || out_ready;
  assign take     = in_valid && in_ready;
  assign wb_live  = wb_en && (wb_addr != '0);

`ifdef OPERAND_FETCH_BYPASS_EN
  logic [REG_AW-1:0] held_rs1;
  logic [REG_AW-1:0] held_rs2;
  logic              held_imm;
  logic              stall;

  assign stall = out_valid && !out_ready;

  // Operand select: forward a writeback landing this cycle.
  always_comb begin
    opa = rf1;
    opb = rf2;
    if (wb_live && (wb_addr == rs1)) opa = wb_data;
    if (wb_live && (wb_addr == rs2)) opb = wb_data;
    if (use_imm) opb = imm;
  end

  // Held source tags so a stalled instruction sees later writebacks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      held_rs1 <= '0;
      held_rs2 <= '0;
      held_imm <= 1'b0;
    end else if (take) begin
      held_rs1 <= rs1;
      held_rs2 <= rs2;
      held_imm <= use_imm;
    end
  end
`else
  // Operand select: plain register read, pre-write value on conflict.
  always_comb begin
    opa = rf1;
    opb = use_imm ? imm : rf2;
  end
`endif

  // Output register: capture, drain, or (with bypass) refresh on stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      a         <= '0;
      b         <= '0;
      out_funct <= '0;
      out_rd    <= '0;
    end else if (take) begin
      out_valid <= 1'b1;
      a         <= opa;
      b         <= opb;
      out_funct <= funct;
      out_rd    <= rd;
    end else if (out_ready) begin
      out_valid <= 1'b0;
`ifdef OPERAND_FETCH_BYPASS_EN
    end else if (stall && wb_live) begin
      if (wb_addr == held_rs1) a <= wb_data;
      if (!held_imm && (wb_addr == held_rs2)) b <= wb_data;
`endif
    end
  end

endmodule
